// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// Instruction fields and MemReady flow in; mux selects, strobes and debug state flow out.
interface multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         Rd;
    logic               MemReady;
    logic               IRWrite;
    logic               NextPC;
    logic               AdrSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUControl;
    logic [1:0]         FlagW;
    logic               RegW;
    logic               MemW;
    logic               PCS;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic [STATE_W-1:0] State;

    modport master (
        input  Op, Funct, Rd, MemReady,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
               FlagW, RegW, MemW, PCS, ImmSrc, RegSrc, State
    );

    modport slave (
        output Op, Funct, Rd, MemReady,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
               FlagW, RegW, MemW, PCS, ImmSrc, RegSrc, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle ARM-subset core: Moore-decoded mux selects and
// unconditioned write strobes, with MemReady stalls in FETCH, MEMRD and MEMWR.
module multicycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXECR  = STATE_W'(6),
        EXECI  = STATE_W'(7),
        ALUWB  = STATE_W'(8),
        BRANCH = STATE_W'(9)
    } state_t;

    state_t     state_q, state_d;

    logic       mem_rdy;
    logic [3:0] cmd;
    logic       s_bit;
    logic       dp_ok;
    logic       is_arith;
    logic [1:0] dp_alu;
    logic [1:0] dp_flagw;

    logic       ir_write, next_pc, adr_src, alu_src_a, reg_w, mem_w, branch;
    logic [1:0] alu_src_b, result_src, alu_control, flag_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Supported DP commands; anything else executes as a harmless ADD with no writes.
    always_comb begin
        cmd      = bus.Funct[4:1];
        s_bit    = bus.Funct[0];
        dp_ok    = 1'b1;
        is_arith = 1'b0;
        dp_alu   = 2'b00;
        case (cmd)
            4'b0100: begin dp_alu = 2'b00; is_arith = 1'b1; end
            4'b0010: begin dp_alu = 2'b01; is_arith = 1'b1; end
            4'b0000: dp_alu = 2'b10;
            4'b1100: dp_alu = 2'b11;
            default: dp_ok = 1'b0;
        endcase
        dp_flagw = dp_ok ? {s_bit, s_bit & is_arith} : 2'b00;
    end

    always_comb begin
        // Reset forces MemReady low so the cleared FETCH state raises no strobes.
        mem_rdy     = reset & (bus.MemReady | ~MEM_WAIT_EN);
        state_d     = FETCH;
        ir_write    = 1'b0;
        next_pc     = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 2'b00;
        flag_w      = 2'b00;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        branch      = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_rdy;
                next_pc    = mem_rdy;
                state_d    = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_d = mem_rdy ? MEMWB : MEMRD;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                state_d = mem_rdy ? FETCH : MEMWR;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            EXECR: begin
                alu_control = dp_alu;
                flag_w      = dp_flagw;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = dp_alu;
                flag_w      = dp_flagw;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_w = dp_ok;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.IRWrite    = ir_write;
    assign bus.NextPC     = next_pc;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.FlagW      = flag_w;
    assign bus.RegW       = reg_w;
    assign bus.MemW       = mem_w;
    assign bus.PCS        = branch | (reg_w & (bus.Rd == 4'd15));
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.State      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are queued by
// the stimulus and compared by a negedge monitor.
module tb_multicycle_ctrl;
    logic       clk;
    logic       rst_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_ready;

    multicycle_ctrl_if #(.STATE_W(4)) bus ();

    assign bus.Op       = op;
    assign bus.Funct    = funct;
    assign bus.Rd       = rd;
    assign bus.MemReady = mem_ready;

    multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [22:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, RegW, MemW, PCS, ImmSrc, RegSrc}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [22:0] act;
            e   = exp_q.pop_front();
            act = {bus.State, bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                   bus.ResultSrc, bus.ALUControl, bus.FlagW, bus.RegW, bus.MemW, bus.PCS,
                   bus.ImmSrc, bus.RegSrc};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s t=%0t: got %b state=%0d, expected %b state=%0d",
                         e.nm, $time, act, act[22:19], e.v, e.v[22:19]);
            end
        end
    end

    task automatic push(input string nm, input int st, input bit irw, npc, adr, asa,
                        input int asb, rs, alu, fw, input bit rw, mw, pcs);
        exp_t e;
        e.nm = nm;
        e.v  = {st[3:0], irw, npc, adr, asa, asb[1:0], rs[1:0], alu[1:0], fw[1:0],
                rw, mw, pcs, op, op == 2'b01, op == 2'b10};
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic t_rst();           push("reset",  0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0); step(); endtask
    task automatic t_fetch(bit r);    push("fetch",  0, r, r, 0, 1, 2, 2, 0, 0, 0, 0, 0); step(); endtask
    task automatic t_decode();        push("decode", 1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0); step(); endtask
    task automatic t_memadr();        push("memadr", 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step(); endtask
    task automatic t_memrd();         push("memrd",  3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step(); endtask
    task automatic t_memwb(bit p);    push("memwb",  4, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, p); step(); endtask
    task automatic t_memwr();         push("memwr",  5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0); step(); endtask
    task automatic t_execr(int a, int f); push("execr", 6, 0, 0, 0, 0, 0, 0, a, f, 0, 0, 0); step(); endtask
    task automatic t_execi(int a, int f); push("execi", 7, 0, 0, 0, 0, 1, 0, a, f, 0, 0, 0); step(); endtask
    task automatic t_aluwb(bit w, bit p); push("aluwb", 8, 0, 0, 0, 0, 0, 0, 0, 0, w, 0, p); step(); endtask
    task automatic t_branch();        push("branch", 9, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1); step(); endtask

    task automatic instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        op = o; funct = f; rd = r;
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1;
        op = 2'b00; funct = 6'b0; rd = 4'd0;
        step();

        // Reset held with MemReady=1: no fetch strobes.
        t_rst(); t_rst(); t_rst();
        rst_n = 1'b1;

        // ADD R1 with S: register operand.
        instr(2'b00, 6'b001001, 4'd1);
        t_fetch(1); t_decode(); t_execr(0, 3); t_aluwb(1, 0);

        // LDR to PC with two MemReady-low cycles in MEMRD.
        instr(2'b01, 6'b011001, 4'd15);
        t_fetch(1); t_decode(); t_memadr();
        mem_ready = 1'b0; t_memrd(); t_memrd();
        mem_ready = 1'b1; t_memrd(); t_memwb(1);

        // STR with one stall cycle in MEMWR.
        instr(2'b01, 6'b011000, 4'd2);
        t_fetch(1); t_decode(); t_memadr();
        mem_ready = 1'b0; t_memwr();
        mem_ready = 1'b1; t_memwr();

        // Branch with one fetch stall.
        instr(2'b10, 6'b000000, 4'd0);
        mem_ready = 1'b0; t_fetch(0);
        mem_ready = 1'b1; t_fetch(1); t_decode(); t_branch();

        // Undefined opcode.
        instr(2'b11, 6'b000000, 4'd0);
        t_fetch(1); t_decode();

        // SUB immediate with S to R15.
        instr(2'b00, 6'b100101, 4'd15);
        t_fetch(1); t_decode(); t_execi(1, 3); t_aluwb(1, 1);

        // AND register with S: only NZ flags.
        instr(2'b00, 6'b000001, 4'd4);
        t_fetch(1); t_decode(); t_execr(2, 2); t_aluwb(1, 0);

        // Unsupported cmd to R15 with MemReady low outside memory states.
        instr(2'b00, 6'b000011, 4'd15);
        t_fetch(1);
        mem_ready = 1'b0; t_decode(); t_execr(0, 0); t_aluwb(0, 0);
        mem_ready = 1'b1;

        // ORR immediate without S, reset asserted mid-ALUWB.
        instr(2'b00, 6'b111000, 4'd3);
        t_fetch(1); t_decode(); t_execi(3, 0);
        push("async_reset", 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        step();
        t_rst();
        rst_n = 1'b1;
        t_fetch(1); t_decode();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle ARM-subset processor.
- Sequences fetch, decode, execute, memory access and writeback over several cycles, and drives the datapath mux selects.
- Produces the unconditioned write strobes (PCS, RegW, MemW, FlagW), which feed the condition-logic block. That block gates them with the condition check.
- Supports a memory-ready handshake so fetch and data accesses can stall.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour MemReady; 0 = treat MemReady as always 1.
- STATE_W, 4: width of the state register and of the State debug port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  instruction [25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S for DP / L for memory.
- Rd  in  4  destination register field.
- MemReady  in  1  memory has completed the current access this cycle.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  unconditional PC update (fetch).
- AdrSrc  out  1  0 = PC, 1 = ALU result as memory address.
- ALUSrcA  out  1  0 = register A, 1 = PC.
- ALUSrcB  out  2  00 = register B, 01 = extended immediate, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- FlagW  out  2  [1] = NZ write, [0] = CV write (unconditioned).
- RegW, MemW  out  1 each  unconditioned register / memory write.
- PCS  out  1  PC written from Result: Branch | (RegW & Rd==15).
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [1] = (Op==01), [0] = (Op==10).
- State  out  STATE_W  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Unused encodings return to FETCH on the next edge.
- State register:
  - Asynchronous clear to FETCH while reset=0.
  - First active edge after reset deasserts evaluates the FETCH transition.
  - Reset mid-instruction abandons the instruction; no write strobe is asserted during reset.
- Outputs are Moore outputs decoded from the state (PCS also uses Rd). Every output not listed for a state is 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite and NextPC only when MemReady=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemW=1 (held until MemReady).
  - MEMWB: ResultSrc=01, RegW=1.
  - EXECR: ALUSrcB=00, with decoded ALUControl and FlagW.
  - EXECI: ALUSrcB=01, with decoded ALUControl and FlagW.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ALUControl=00, Branch (PCS=1).
- Outputs while reset=0 are the FETCH values with MemReady forced to 0, so IRWrite=NextPC=0.
- Transitions:
  - FETCH -> DECODE when MemReady; otherwise stay.
  - DECODE -> MEMADR if Op=01; EXECI if Op=00 & Funct[5]; EXECR if Op=00 & !Funct[5]; BRANCH if Op=10; FETCH if Op=11 (no strobes).
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB when MemReady; otherwise stay.
  - MEMWR -> FETCH when MemReady; otherwise stay.
  - MEMWB, ALUWB, BRANCH -> FETCH.
  - EXECR, EXECI -> ALUWB.
- ALU decode (EXECR/EXECI only), by cmd:
  - 0100 -> ADD, ALUControl=00.
  - 0010 -> SUB, ALUControl=01.
  - 0000 -> AND, ALUControl=10.
  - 1100 -> ORR, ALUControl=11.
  - Any other cmd -> ALUControl=00, FlagW=00, and ALUWB asserts RegW=0 (no architectural effect).
  - FlagW[1] = S; FlagW[0] = S & (ADD|SUB).
- Latencies (MemReady=1): DP = 4 cycles, LDR = 5, STR = 4, B = 3, undefined = 2.
- Each cycle MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- A MemReady pulse in any other state is ignored.

Test Plan:
- Reset: hold reset=0 three cycles with MemReady=1 -> State=0, IRWrite=NextPC=RegW=MemW=0; release -> IRWrite=1 in that cycle, State=1 next.
- ADD R1,R2,R3 with S set (Op=00, Funct=001001, Rd=1) -> states 0,1,6,8,0; in EXECR ALUControl=00 and FlagW=11; in ALUWB RegW=1, PCS=0.
- LDR with Rd=15 (Op=01, Funct=011001): hold MemReady=0 for 2 cycles in MEMRD -> State stays 3 for 3 cycles; then MEMWB with RegW=1 and PCS=1.
- STR (Funct[0]=0): MemReady low 1 cycle -> MemW=1 for 2 cycles in MEMWR; then FETCH with RegW never asserted.
- Branch (Op=10) -> states 0,1,9,0; PCS=1 and ResultSrc=10 in BRANCH. Undefined (Op=11) -> 0,1,0 with no strobes.
- ORR immediate without S (Funct=111000) -> EXECI with ALUControl=11, FlagW=00. Assert reset=0 during ALUWB -> State=0 immediately and RegW drops asynchronously.
